// File: rtl/axis_elastic_buffer.sv
// rtl/axis_elastic_buffer.sv - DEPTH-entry AXI-Stream elastic buffer with registered outputs,
// occupancy count, synchronous flush and optional store-and-forward packet mode.
module axis_elastic_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WD     = $clog2(DATA_BYTE_WIDTH),
  parameter int DEPTH           = 4,
  parameter bit PKT_MODE        = 1'b0,
  parameter int CNT_WD          = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic [BYTE_CNT_WD-1:0]     byte_insert_cnt_in,
  input  logic                       last_in,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic [BYTE_CNT_WD-1:0]     byte_insert_cnt_out,
  output logic                       last_out,
  output logic                       ready_out,
  output logic [CNT_WD-1:0]          count
);
  localparam int BW  = DATA_WIDTH + DATA_BYTE_WIDTH + BYTE_CNT_WD + 1;
  localparam int SD  = DEPTH - 1;
  localparam int STW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic {HOLD, FWD} state_e;

  state_e            state_q;
  logic              valid_q, ready_q;
  logic [CNT_WD-1:0] count_q, count_d, lasts_q, lasts_d;
  logic [BW-1:0]     head_q, beat_in;
  logic [BW-1:0]     mem_q [SD];
  logic [STW-1:0]    wr_q, rd_q;
  logic              push, pop, load_direct, load_mem, wr_mem;

  function automatic logic [STW-1:0] ptr_inc(input logic [STW-1:0] p);
    return (p == STW'(SD - 1)) ? '0 : p + STW'(1);
  endfunction

  assign beat_in = {data_in, keep_in, byte_insert_cnt_in, last_in};
  assign {data_out, keep_out, byte_insert_cnt_out, last_out} = head_q;
  assign valid_out = valid_q;
  assign ready_out = ready_q;
  assign count     = count_q;

  assign push = valid_in & ready_q & ~flush;
  assign pop  = valid_q & ready_in;

  // The head register takes the incoming beat directly when no stored beat is ahead of it.
  assign load_direct = push & ((count_q == '0) | (pop & (count_q == CNT_WD'(1))));
  assign load_mem    = pop & ~flush & (count_q > CNT_WD'(1));
  assign wr_mem      = push & ~load_direct;

  always_comb begin
    count_d = count_q + CNT_WD'(push) - CNT_WD'(pop);
    lasts_d = lasts_q + CNT_WD'(push & last_in) - CNT_WD'(pop & last_out);
    if (flush) begin
      count_d = '0;
      lasts_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_mem) mem_q[wr_q] <= beat_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      count_q <= '0;
      lasts_q <= '0;
      ready_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      count_q <= count_d;
      lasts_q <= lasts_d;
      ready_q <= (count_d < CNT_WD'(DEPTH));
      if (load_direct) head_q <= beat_in;
      else if (load_mem) head_q <= mem_q[rd_q];
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (wr_mem) wr_q <= ptr_inc(wr_q);
        if (load_mem) rd_q <= ptr_inc(rd_q);
      end
    end
  end

  // HOLD->FWD on a complete packet, or on a full buffer so oversize packets cannot deadlock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      valid_q <= 1'b0;
    end else if (!PKT_MODE) begin
      valid_q <= (count_d != '0);
    end else if (flush) begin
      state_q <= HOLD;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if ((lasts_d != '0) || (count_d == CNT_WD'(DEPTH))) begin
            state_q <= FWD;
            valid_q <= (count_d != '0);
          end else begin
            valid_q <= 1'b0;
          end
        end
        FWD: begin
          if (pop && last_out && (lasts_d == '0)) begin
            state_q <= HOLD;
            valid_q <= 1'b0;
          end else begin
            valid_q <= (count_d != '0);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axis_elastic_buffer.sv
// tb/tb_axis_elastic_buffer.sv - self-checking bench for axis_elastic_buffer (cut-through and packet mode).
module tb_axis_elastic_buffer;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [1:0]  bic;
    logic        last;
  } beat_t;

  typedef struct {
    bit vin;
    bit rdy;
    bit vo;
    bit ro;
    int cnt;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, vin = 1'b0, vlast = 1'b0, rdy = 1'b0;
  logic [31:0] vdata = '0;
  logic [3:0]  vkeep = '0;
  logic [1:0]  vbic = '0;
  logic        vo [4], ro [4], lo [4];
  logic [31:0] dout [4];
  logic [3:0]  ko [4];
  logic [1:0]  bo [4];
  logic [2:0]  c0, c3;
  logic [3:0]  c1, c2;

  int    checks = 0, errors = 0, sel = 0, seq = 0, mlasts = 0;
  bit    mst = 1'b0, dead_seen = 1'b0;
  beat_t q[$];
  vec_t  tbl [10];

  always #5 clk = ~clk;

  // u0: DEPTH4 cut-through, u1: DEPTH8 cut-through, u2: DEPTH8 packet, u3: DEPTH4 packet
  axis_elastic_buffer #(.DEPTH(4), .PKT_MODE(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(vin), .data_in(vdata), .keep_in(vkeep),
    .byte_insert_cnt_in(vbic), .last_in(vlast), .ready_in(rdy), .valid_out(vo[0]), .data_out(dout[0]),
    .keep_out(ko[0]), .byte_insert_cnt_out(bo[0]), .last_out(lo[0]), .ready_out(ro[0]), .count(c0));
  axis_elastic_buffer #(.DEPTH(8), .PKT_MODE(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(vin), .data_in(vdata), .keep_in(vkeep),
    .byte_insert_cnt_in(vbic), .last_in(vlast), .ready_in(rdy), .valid_out(vo[1]), .data_out(dout[1]),
    .keep_out(ko[1]), .byte_insert_cnt_out(bo[1]), .last_out(lo[1]), .ready_out(ro[1]), .count(c1));
  axis_elastic_buffer #(.DEPTH(8), .PKT_MODE(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(vin), .data_in(vdata), .keep_in(vkeep),
    .byte_insert_cnt_in(vbic), .last_in(vlast), .ready_in(rdy), .valid_out(vo[2]), .data_out(dout[2]),
    .keep_out(ko[2]), .byte_insert_cnt_out(bo[2]), .last_out(lo[2]), .ready_out(ro[2]), .count(c2));
  axis_elastic_buffer #(.DEPTH(4), .PKT_MODE(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(vin), .data_in(vdata), .keep_in(vkeep),
    .byte_insert_cnt_in(vbic), .last_in(vlast), .ready_in(rdy), .valid_out(vo[3]), .data_out(dout[3]),
    .keep_out(ko[3]), .byte_insert_cnt_out(bo[3]), .last_out(lo[3]), .ready_out(ro[3]), .count(c3));

  function automatic int cnt_of(input int s);
    case (s)
      0:       return int'(c0);
      1:       return int'(c1);
      2:       return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s sel=%0d actual=%0h required=%0h t=%0t", name, sel, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit l);
    vin   = v;
    vlast = l;
    vdata = seq;
    vkeep = 4'(seq ^ 9);
    vbic  = 2'(seq);
  endtask

  // One clock: predict from the pre-edge inputs, advance, then compare after the edge.
  task automatic cyc();
    bit    push, pop, plast, evo;
    int    d;
    beat_t b;
    d     = (sel == 1 || sel == 2) ? 8 : 4;
    push  = vin && ro[sel] && !flush;
    pop   = vo[sel] && rdy;
    plast = 1'b0;
    if (pop) begin
      chk("pop_has_beat", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        b = q.pop_front();
        plast = b.last;
        if (plast) mlasts--;
      end
    end
    if (push) begin
      b.data = vdata; b.keep = vkeep; b.bic = vbic; b.last = vlast;
      q.push_back(b);
      if (vlast) mlasts++;
      seq++;
    end
    if (flush) begin
      q.delete();
      mlasts = 0;
    end
    evo = (q.size() != 0);
    if (sel >= 2) begin
      if (flush) mst = 1'b0;
      else if (!mst && (mlasts > 0 || q.size() == d)) mst = 1'b1;
      else if (mst && pop && plast && mlasts == 0) mst = 1'b0;
      evo = mst && (q.size() != 0);
    end
    @(posedge clk);
    #1;
    chk("count", 64'(cnt_of(sel)), 64'(q.size()));
    chk("ready_out", 64'(ro[sel]), 64'(q.size() < d));
    chk("valid_out", 64'(vo[sel]), 64'(evo));
    if (vo[sel] && q.size() > 0) begin
      chk("data_out", 64'(dout[sel]), 64'(q[0].data));
      chk("keep_out", 64'(ko[sel]), 64'(q[0].keep));
      chk("bic_out", 64'(bo[sel]), 64'(q[0].bic));
      chk("last_out", 64'(lo[sel]), 64'(q[0].last));
    end
    if (vo[sel] && dout[sel] == 32'hDEADBEEF) dead_seen = 1'b1;
  endtask

  // Asynchronous reset pulse launched between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    vin   = 1'b0;
    flush = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      chk("rst_valid", 64'(vo[s]), 64'd0);
      chk("rst_ready", 64'(ro[s]), 64'd0);
      chk("rst_data", 64'({dout[s], ko[s], bo[s], lo[s]}), 64'd0);
      chk("rst_count", 64'(cnt_of(s)), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    mlasts = 0;
    mst    = 1'b0;
    seq    = 0;
    chk("rst_ready_still_low", 64'(ro[0]), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_release", 64'(ro[0]), 64'd1);
  endtask

  initial begin
    int first, hi, gaps, popped;
    tbl[0] = '{1, 0, 1, 1, 1};
    tbl[1] = '{1, 0, 1, 1, 2};
    tbl[2] = '{1, 0, 1, 1, 3};
    tbl[3] = '{1, 0, 1, 0, 4};
    tbl[4] = '{1, 0, 1, 0, 4};
    tbl[5] = '{1, 1, 1, 1, 3};
    tbl[6] = '{0, 1, 1, 1, 2};
    tbl[7] = '{0, 1, 1, 1, 1};
    tbl[8] = '{0, 1, 0, 1, 0};
    tbl[9] = '{0, 0, 0, 1, 0};

    do_reset();

    // back-to-back stream through DEPTH=4
    sel = 0;
    rdy = 1'b1;
    for (int i = 0; i < 20 && seq < 16; i++) begin
      drive(1'b1, seq == 15);
      cyc();
      chk("t1_count_one", 64'(c0), 64'd1);
      chk("t1_latency", 64'(dout[0]), 64'(seq - 1));
    end
    drive(1'b0, 1'b0);
    cyc();
    cyc();

    // fill with ready_in low, then drain
    do_reset();
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].vin, 1'b0);
      rdy = tbl[i].rdy;
      cyc();
      chk("tbl_valid", 64'(vo[0]), 64'(tbl[i].vo));
      chk("tbl_ready", 64'(ro[0]), 64'(tbl[i].ro));
      chk("tbl_count", 64'(c0), 64'(tbl[i].cnt));
    end

    // flush with three beats held and a beat presented
    do_reset();
    sel = 0;
    rdy = 1'b0;
    dead_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      cyc();
    end
    flush = 1'b1;
    drive(1'b1, 1'b0);
    vdata = 32'hDEADBEEF;
    cyc();
    flush = 1'b0;
    chk("flush_valid", 64'(vo[0]), 64'd0);
    chk("flush_count", 64'(c0), 64'd0);
    chk("flush_ready", 64'(ro[0]), 64'd1);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      cyc();
    end
    drive(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    chk("flush_beat_dropped", 64'(dead_seen), 64'd0);

    // packet mode, DEPTH=8, 3-beat packet
    do_reset();
    sel = 2;
    rdy = 1'b1;
    first = -1;
    hi = 0;
    for (int n = 0; n < 12; n++) begin
      drive(seq < 3, seq == 2);
      cyc();
      if (vo[2]) begin
        if (first < 0) first = n;
        hi++;
      end
    end
    chk("pkt3_first_valid", 64'(first), 64'd2);
    chk("pkt3_beats", 64'(hi), 64'd3);

    // packet mode, DEPTH=4, 10-beat packet exceeds capacity
    do_reset();
    sel = 3;
    rdy = 1'b1;
    first = -1;
    gaps = 0;
    popped = 0;
    for (int n = 0; n < 30; n++) begin
      if (vo[3] && rdy) popped++;
      drive(seq < 10, seq == 9);
      cyc();
      if (vo[3] && first < 0) first = n;
      if (first >= 0 && !vo[3] && popped < 9) gaps++;
    end
    chk("pkt10_first_valid", 64'(first), 64'd3);
    chk("pkt10_gaps", 64'(gaps), 64'd0);
    chk("pkt10_popped", 64'(popped), 64'd10);
    drive(1'b1, 1'b0);
    cyc();
    drive(1'b0, 1'b0);
    cyc();
    cyc();
    chk("pkt10_back_in_hold", 64'(vo[3]), 64'd0);

    // random traffic, DEPTH=8, with an asynchronous reset mid-burst
    do_reset();
    sel = 1;
    for (int n = 0; n < 1000; n++) begin
      rdy = ($urandom % 3) != 0;
      drive(($urandom % 4) != 0, ($urandom % 5) == 0);
      cyc();
      if (n == 600) begin
        do_reset();
        sel = 1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
